// File: rtl/regfile_writeback.sv
// regfile_writeback: write side of the register-file port.
// Merges single-cycle ALU results and FIFO-buffered memory results into one
// registered write per cycle. ALU wins arbitration unless the starvation
// counter has saturated while memory results are waiting.
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   alu_valid/rd/data     ALU result offer; alu_stall asks upstream to hold it
//   mem_valid/rd/data     memory result offer; mem_ready completes handshake
//   regd/regWrite/dataWrite  registered register-file write port
//   pending               FIFO occupancy

package regfile_writeback_pkg;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [RD_W-1:0]       alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_stall,
  input  logic                  mem_valid,
  input  logic [RD_W-1:0]       mem_rd,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  mem_ready,
  output logic [RD_W-1:0]       regd,
  output logic                  regWrite,
  output logic [DATA_W-1:0]     dataWrite,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SC_W  = $clog2(STARVE_MAX + 1);

  wb_entry_t        fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SC_W-1:0]  starve_q, starve_d;
  wb_entry_t        out_q, out_d;
  logic             wen_q, wen_d;

  logic full, nonempty, alu_take, fifo_take, push;

  // Arbitration and handshake decode, all from registered state plus inputs
  assign full      = (count_q == CNT_W'(DEPTH));
  assign nonempty  = (count_q != '0);
  assign mem_ready = !full;
  assign alu_stall = (starve_q == SC_W'(STARVE_MAX)) && nonempty;
  assign alu_take  = alu_valid && !alu_stall && (alu_rd != '0);
  assign fifo_take = nonempty && !alu_take;
  // rd==0 offers complete the handshake but are dropped, never stored
  assign push      = mem_valid && !full && (mem_rd != '0);

  // FIFO pointer/occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push)      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (fifo_take) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !fifo_take)      count_d = count_q + CNT_W'(1);
    else if (!push && fifo_take) count_d = count_q - CNT_W'(1);
  end

  // Starvation counter: counts ALU wins while memory results wait
  always_comb begin
    starve_d = starve_q;
    if (fifo_take || !nonempty) begin
      starve_d = '0;
    end else if (alu_take && (starve_q != SC_W'(STARVE_MAX))) begin
      starve_d = starve_q + SC_W'(1);
    end
  end

  // Write-port next state; regd/dataWrite hold when idle
  always_comb begin
    wen_d = 1'b0;
    out_d = out_q;
    if (alu_take) begin
      wen_d = 1'b1;
      out_d = '{rd: alu_rd, data: alu_data};
    end else if (fifo_take) begin
      wen_d = 1'b1;
      out_d = fifo_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      out_q    <= '0;
      wen_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      out_q    <= out_d;
      wen_q    <= wen_d;
    end
  end

  // Storage needs no reset: occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{rd: mem_rd, data: mem_data};
  end

  assign regd      = out_q.rd;
  assign dataWrite = out_q.data;
  assign regWrite  = wen_q;
  assign pending   = count_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: expected writes (with due cycle) are queued
// when stimulus is driven; a monitor pops them as the write port fires.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [4:0]  regd;
  logic        regWrite;
  logic [31:0] dataWrite;
  logic [2:0]  pending;

  regfile_writeback #(.DEPTH(4), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .regd(regd), .regWrite(regWrite), .dataWrite(dataWrite), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        exp_stall;
    logic        exp_ready;
    logic        exp_alu_wr;
    logic        exp_mem_wr;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] data, input int due);
    exp_t e;
    e.rd = rd; e.data = data; e.due = due;
    sb.push_back(e);
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Write-port monitor: every cycle either the due write or no write
  always @(posedge clk) begin
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("wr_en", 32'(regWrite), 32'd1);
      chk("wr_rd", 32'(regd), 32'(e.rd));
      chk("wr_data", dataWrite, e.data);
    end else begin
      chk("no_wr", 32'(regWrite), 32'd0);
    end
  end

  vec_t vecs[7];

  initial begin
    int k;
    vecs[0] = '{1'b1, 5'd5,  32'h1234,     1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 32'hCAFE, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd1, 32'hA5A5, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 5'd0,  32'hDEAD,     1'b1, 5'd0, 32'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 5'd0,  32'h5555,     1'b1, 5'd3, 32'h33,   1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 5'd6,  32'h66,       1'b0, 5'd8, 32'h88,   1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 5'd17, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b1, 1'b0};

    reset = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    #1;
    chk("rst_regwrite", 32'(regWrite), 32'd0);
    chk("rst_regd", 32'(regd), 32'd0);
    chk("rst_data", dataWrite, 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_ready", 32'(mem_ready), 32'd1);
    chk("rst_stall", 32'(alu_stall), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Single-transaction vectors from an empty FIFO
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].mv, vecs[i].mrd, vecs[i].md);
      k = cyc;
      if (vecs[i].exp_alu_wr) push_exp(vecs[i].ard, vecs[i].ad, k + 1);
      if (vecs[i].exp_mem_wr) push_exp(vecs[i].mrd, vecs[i].md, k + 2);
      #1;
      chk($sformatf("vec%0d_stall", i), 32'(alu_stall), 32'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_ready", i), 32'(mem_ready), 32'(vecs[i].exp_ready));
      idle(3);
      chk($sformatf("vec%0d_pending", i), 32'(pending), 32'd0);
    end

    // Fill FIFO under ALU pressure; 5th offer held while full
    drive(1'b1, 5'd20, 32'h100, 1'b1, 5'd1, 32'h11);
    k = cyc;
    push_exp(5'd20, 32'h100, k + 1);
    push_exp(5'd21, 32'h101, k + 2);
    push_exp(5'd22, 32'h102, k + 3);
    push_exp(5'd23, 32'h103, k + 4);
    push_exp(5'd1,  32'h11,  k + 5);
    push_exp(5'd24, 32'h104, k + 6);
    push_exp(5'd2,  32'h12,  k + 7);
    push_exp(5'd3,  32'h13,  k + 8);
    push_exp(5'd4,  32'h14,  k + 9);
    push_exp(5'd5,  32'h15,  k + 10);
    drive(1'b1, 5'd21, 32'h101, 1'b1, 5'd2, 32'h12);
    drive(1'b1, 5'd22, 32'h102, 1'b1, 5'd3, 32'h13);
    drive(1'b1, 5'd23, 32'h103, 1'b1, 5'd4, 32'h14);
    drive(1'b1, 5'd24, 32'h104, 1'b1, 5'd5, 32'h15);
    #1;
    chk("full_pending", 32'(pending), 32'd4);
    chk("full_ready", 32'(mem_ready), 32'd0);
    chk("full_stall", 32'(alu_stall), 32'd1);
    drive(1'b1, 5'd24, 32'h104, 1'b1, 5'd5, 32'h15);
    #1;
    chk("after_pop_pending", 32'(pending), 32'd3);
    chk("after_pop_ready", 32'(mem_ready), 32'd1);
    chk("after_pop_stall", 32'(alu_stall), 32'd0);
    idle(6);
    chk("drained_pending", 32'(pending), 32'd0);

    // Starvation: one queued entry, ALU valid every cycle
    drive(1'b1, 5'd25, 32'h200, 1'b1, 5'd12, 32'h1200);
    k = cyc;
    push_exp(5'd25, 32'h200,  k + 1);
    push_exp(5'd26, 32'h201,  k + 2);
    push_exp(5'd27, 32'h202,  k + 3);
    push_exp(5'd28, 32'h203,  k + 4);
    push_exp(5'd12, 32'h1200, k + 5);
    push_exp(5'd29, 32'h204,  k + 6);
    #1 chk("starve0_stall", 32'(alu_stall), 32'd0);
    drive(1'b1, 5'd26, 32'h201, 1'b0, 5'd0, 32'h0);
    #1 chk("starve1_stall", 32'(alu_stall), 32'd0);
    drive(1'b1, 5'd27, 32'h202, 1'b0, 5'd0, 32'h0);
    #1 chk("starve2_stall", 32'(alu_stall), 32'd0);
    drive(1'b1, 5'd28, 32'h203, 1'b0, 5'd0, 32'h0);
    #1 chk("starve3_stall", 32'(alu_stall), 32'd0);
    drive(1'b1, 5'd29, 32'h204, 1'b0, 5'd0, 32'h0);
    #1 chk("starve_sat_stall", 32'(alu_stall), 32'd1);
    drive(1'b1, 5'd29, 32'h204, 1'b0, 5'd0, 32'h0);
    #1 chk("starve_release_stall", 32'(alu_stall), 32'd0);
    idle(3);
    chk("starve_pending", 32'(pending), 32'd0);

    // Reset with two queued entries discards them
    drive(1'b1, 5'd9, 32'h900, 1'b1, 5'd10, 32'hA0);
    k = cyc;
    push_exp(5'd9, 32'h900, k + 1);
    push_exp(5'd9, 32'h901, k + 2);
    drive(1'b1, 5'd9, 32'h901, 1'b1, 5'd11, 32'hB0);
    idle(1);
    #1 chk("prerst_pending", 32'(pending), 32'd2);
    reset = 1'b0;
    #1;
    chk("midrst_pending", 32'(pending), 32'd0);
    chk("midrst_ready", 32'(mem_ready), 32'd1);
    chk("midrst_regwrite", 32'(regWrite), 32'd0);
    chk("midrst_stall", 32'(alu_stall), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(5);
    chk("postrst_pending", 32'(pending), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
